alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: LANES, 16, number of 32-bit lanes; data width W = 32*LANES.
REQ-002 Parameter: ALU_LAT, 1, ALU result latency in clock edges from operand-valid edge; legal range 1..7.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, with these ports:
- clock  in  1  single clock; all state updates on its rising edge
- reset_n  in  1  asynchronous active-low reset
REQ-004 Requester ports, for n in {0,1}:
- reqN_valid  in  1  request pending
- reqN_ready  out  1  request accepted this cycle
- reqN_op  in  1  0 = ADD, 1 = MULL
- reqN_a, reqN_b  in  W  operands
REQ-005 ALU-side ports:
- alu_op  out  1  operation to ALU
- alu_a, alu_b  out  W  operands to ALU
- alu_lo, alu_hi  in  W  ALU low/high result halves
REQ-006 Response ports:
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts
- rsp_id  out  1  granted requester
- rsp_lo, rsp_hi  out  W  captured result halves
REQ-007 Status ports:
- busy  out  1  state != IDLE
- cnt0, cnt1  out  16  completed-response counters per requester

Function
REQ-008 The FSM SHALL have exactly three states: IDLE, ISSUE and RESP.
REQ-009 In IDLE, reqN_ready SHALL be combinational: high only for the granted requester, and only while its reqN_valid is high; in ISSUE and RESP both ready outputs SHALL be 0.
REQ-010 Arbitration SHALL be round-robin with a 1-bit priority pointer.
- Only one requester valid: that requester is granted.
- Both valid: the requester indicated by the pointer is granted.
- After each accepted request, the pointer SHALL point to the non-granted requester.
REQ-011 On an accept edge, the block SHALL:
- register op, a and b onto the alu_* outputs;
- record rsp_id;
- clear the latency counter;
- enter ISSUE.
REQ-012 The alu_* outputs SHALL hold their values unchanged from the accept edge until the next accept.
REQ-013 ISSUE timing:
- The latency counter SHALL increment on each edge in ISSUE.
- On the (ALU_LAT+1)-th edge after accept, alu_lo/alu_hi SHALL be captured into rsp_lo/rsp_hi, rsp_valid SHALL go to 1, and the state SHALL become RESP.
- Accept-to-rsp_valid latency is therefore ALU_LAT+1 cycles.
REQ-014 In RESP, rsp_valid, rsp_id, rsp_lo and rsp_hi SHALL remain stable until an edge with rsp_ready=1.
REQ-015 On that edge, rsp_valid SHALL go to 0, cnt[rsp_id] SHALL increment (16-bit wrap, 0xFFFF to 0x0000), and the state SHALL become IDLE.
REQ-016 No request SHALL be accepted on the RESP-exit edge; the earliest next accept is one cycle later, so at most one operation is outstanding.
REQ-017 A requester dropping valid before it is accepted SHALL cause no side effects.
REQ-018 rsp_ready asserted outside RESP SHALL be ignored.
REQ-019 Result halves SHALL be passed through unmodified; the block performs no arithmetic on data.

Reset
REQ-020 While reset_n=0, independent of clock, the block SHALL hold:
- state IDLE and priority pointer at requester 0;
- rsp_valid=0, rsp_id=0, rsp_lo=0, rsp_hi=0;
- alu_op=0, alu_a=0, alu_b=0;
- latency counter 0, cnt0=0, cnt1=0.
REQ-021 Reset asserted mid-ISSUE or mid-RESP SHALL abandon the operation with no response and no counter change.

Structure
REQ-022 A shared package SHALL hold:
- op encodings ADD=1'b0, MULL=1'b1;
- the FSM state enum;
- the W derivation from LANES.
REQ-023 The block SHALL have one sub-module, rr_arb2: a 2-input round-robin grant with pointer register and update-on-accept input.

Verification
REQ-024 Single ADD: req0 valid with op=0, lane0 a=5, b=7, ALU_LAT=1 -> rsp_valid 2 cycles after accept; rsp_lo lane0=12, rsp_hi lane0=0, rsp_id=0.
REQ-025 MULL overflow: req1 with lane15 a=b=0xFFFF_FFFF -> rsp_lo lane15=0x0000_0001, rsp_hi lane15=0xFFFF_FFFE, rsp_id=1.
REQ-026 Contention: both valid continuously with rsp_ready=1 -> grants alternate 0,1,0,1; cnt0=cnt1=2 after four responses.
REQ-027 Backpressure: rsp_ready=0 for 10 cycles in RESP -> response fields stable; both ready outputs 0; one response only.
REQ-028 Reset mid-ISSUE: reset_n low one cycle after accept -> all outputs 0, no response; next request after reset is granted to req0.
REQ-029 Counter wrap: preload or run 65536 req0 responses -> cnt0 wraps to 0; cnt1 unchanged.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_pkg
// Description : Shared definitions for the two-requester ALU arbiter.
//               Holds the operation encodings, the controller state encoding
//               and the datapath width derivation from the lane count.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package alu_arbiter_pkg;

    // Width of one data lane in bits.
    localparam int c_LANE_W = 32;

    // Operation encodings presented on reqN_op and alu_op.
    localparam logic c_OP_ADD  = 1'b0;
    localparam logic c_OP_MULL = 1'b1;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Total operand / result width for a given number of lanes.
    function automatic int calc_width(input int lanes);
        return c_LANE_W * lanes;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-input round-robin grant. The grant is combinational from
//               the request lines and a 1-bit priority pointer; the pointer
//               moves to the non-granted requester on every accept.
// Ports       : clock       - rising-edge clock
//               reset_n     - asynchronous active-low reset (pointer -> 0)
//               valid0/1    - request lines
//               accept      - grant was taken this cycle, update pointer
//               grant_valid - at least one request is present
//               grant_id    - index of the granted requester
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import alu_arbiter_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic valid0,
    input  logic valid1,
    input  logic accept,
    output logic grant_valid,
    output logic grant_id
);

    logic r_ptr;
    logic w_id;

    // A lone requester always wins; the pointer only breaks ties.
    always_comb begin
        w_id = 1'b0;
        if (valid0 && valid1) begin
            w_id = r_ptr;
        end else if (valid1) begin
            w_id = 1'b1;
        end
    end

    assign grant_valid = valid0 | valid1;
    assign grant_id    = w_id;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= 1'b0;
        end else if (accept) begin
            r_ptr <= ~w_id;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one wide ALU between two requesters. A round-robin
//               grant accepts one request at a time, registers its operands
//               onto the ALU port, waits ALU_LAT+1 edges, captures the result
//               halves and holds them as a response until consumed. At most
//               one operation is outstanding.
// Ports       : clock, reset_n           - clock / async active-low reset
//               reqN_valid/ready/op/a/b  - requester N (N = 0, 1)
//               alu_op/a/b               - operation and operands to the ALU
//               alu_lo/hi                - ALU result halves
//               rsp_valid/ready/id/lo/hi - response handshake and payload
//               busy                     - controller not idle
//               cnt0, cnt1               - completed responses per requester
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int  LANES   = 16,
    parameter int  ALU_LAT = 1,      // legal range 1..7
    localparam int W       = calc_width(LANES)
) (
    input  logic         clock,
    input  logic         reset_n,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic         req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic         req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,

    output logic         alu_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_lo,
    input  logic [W-1:0] alu_hi,

    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_lo,
    output logic [W-1:0] rsp_hi,

    output logic         busy,
    output logic [15:0]  cnt0,
    output logic [15:0]  cnt1
);

    // Counter value seen on the capture edge. The counter is cleared on the
    // accept edge and counts ISSUE edges, so the (ALU_LAT+1)-th edge after
    // accept is the ISSUE edge where it already holds ALU_LAT.
    localparam logic [3:0] c_LAT_LAST = 4'(ALU_LAT);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [3:0]   r_lat;
    logic         r_alu_op;
    logic [W-1:0] r_alu_a;
    logic [W-1:0] r_alu_b;
    logic         r_rsp_valid;
    logic         r_rsp_id;
    logic [W-1:0] r_rsp_lo;
    logic [W-1:0] r_rsp_hi;
    logic [15:0]  r_cnt0;
    logic [15:0]  r_cnt1;

    logic         w_grant_valid;
    logic         w_grant_id;
    logic         w_accept;
    logic         w_capture;
    logic         w_release;
    logic         w_inc0;
    logic         w_inc1;

    rr_arb2 u_rr_arb2 (
        .clock       (clock),
        .reset_n     (reset_n),
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .accept      (w_accept),
        .grant_valid (w_grant_valid),
        .grant_id    (w_grant_id)
    );

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ready is only ever offered from IDLE, so the RESP-exit edge cannot
    // also accept a new request.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_accept    = 1'b1;
                    req0_ready  = ~w_grant_id;
                    req1_ready  = w_grant_id;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (r_lat == c_LAT_LAST) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand, latency and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_alu_op    <= c_OP_ADD;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_rsp_id    <= 1'b0;
            r_lat       <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_lo    <= '0;
            r_rsp_hi    <= '0;
        end else begin
            if (w_accept) begin
                r_alu_op <= w_grant_id ? req1_op : req0_op;
                r_alu_a  <= w_grant_id ? req1_a  : req0_a;
                r_alu_b  <= w_grant_id ? req1_b  : req0_b;
                r_rsp_id <= w_grant_id;
                r_lat    <= 4'd0;
            end else if (r_state == ST_ISSUE) begin
                r_lat <= r_lat + 4'd1;
            end

            if (w_capture) begin
                r_rsp_valid <= 1'b1;
                r_rsp_lo    <= alu_lo;
                r_rsp_hi    <= alu_hi;
            end else if (w_release) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Completion counters (free-running 16-bit wrap)
    // ------------------------------------------------------------------
    assign w_inc0 = w_release & ~r_rsp_id;
    assign w_inc1 = w_release &  r_rsp_id;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt0 <= 16'd0;
            r_cnt1 <= 16'd0;
        end else begin
            r_cnt0 <= r_cnt0 + {15'd0, w_inc0};
            r_cnt1 <= r_cnt1 + {15'd0, w_inc1};
        end
    end

    assign alu_op    = r_alu_op;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_lo    = r_rsp_lo;
    assign rsp_hi    = r_rsp_hi;
    assign busy      = (r_state != ST_IDLE);
    assign cnt0      = r_cnt0;
    assign cnt1      = r_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter. Table of single-request
//               vectors plus directed sequences for backpressure, contention,
//               reset during ISSUE, idle rsp_ready and counter wrap. A per-lane
//               ADD/MULL model stands in for the ALU.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int LANES   = 16;
    localparam int ALU_LAT = 1;
    localparam int W       = 32 * LANES;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         req0_valid, req0_ready, req0_op;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_op;
    logic [W-1:0] req1_a, req1_b;
    logic         alu_op;
    logic [W-1:0] alu_a, alu_b, alu_lo, alu_hi;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0] rsp_lo, rsp_hi;
    logic         busy;
    logic [15:0]  cnt0, cnt1;

    int           checks = 0;
    int           errors = 0;
    logic [15:0]  exp_cnt0 = 16'd0;
    logic [15:0]  exp_cnt1 = 16'd0;

    typedef struct {
        logic        id;
        logic        op;
        int          lane;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
    } vec_t;

    vec_t vecs [8];

    always #5 clock = ~clock;

    alu_arbiter #(.LANES(LANES), .ALU_LAT(ALU_LAT)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_lo     (alu_lo),
        .alu_hi     (alu_hi),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_lo     (rsp_lo),
        .rsp_hi     (rsp_hi),
        .busy       (busy),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    // Per-lane ALU model: ADD gives {carry, sum}, MULL gives the 64-bit product.
    function automatic logic [63:0] lane_alu(input logic op, input logic [31:0] a, input logic [31:0] b);
        if (op == c_OP_MULL) return {32'd0, a} * {32'd0, b};
        return {32'd0, a} + {32'd0, b};
    endfunction

    for (genvar g = 0; g < LANES; g++) begin : g_alu
        logic [63:0] res;
        assign res                  = lane_alu(alu_op, alu_a[g*32 +: 32], alu_b[g*32 +: 32]);
        assign alu_lo[g*32 +: 32]   = res[31:0];
        assign alu_hi[g*32 +: 32]   = res[63:32];
    end

    function automatic logic [W-1:0] lane_vec(input int lane, input logic [31:0] val);
        logic [W-1:0] v;
        v = '0;
        v[lane*32 +: 32] = val;
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive_req(input logic id, input logic v, input logic op,
                             input logic [W-1:0] a, input logic [W-1:0] b);
        if (!id) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    task automatic run_op(input logic id, input logic op, input int lane,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input int stall);
        logic [W-1:0] va, vb;
        int           lat;
        logic         ok;
        va = lane_vec(lane, a);
        vb = lane_vec(lane, b);
        @(negedge clock);
        drive_req(id, 1'b1, op, va, vb);
        #1;
        chk("grant", {req1_ready, req0_ready}, id ? 2'b10 : 2'b01);
        @(posedge clock);
        @(negedge clock);
        drive_req(id, 1'b0, c_OP_ADD, '0, '0);
        chk("busy_issue", busy, 1'b1);
        chk("alu_op", alu_op, op);
        chk("alu_a", alu_a, va);
        chk("alu_b", alu_b, vb);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        chk("rsp_latency", lat, ALU_LAT + 1);
        chk("rsp_id", rsp_id, id);
        chk("rsp_lo", rsp_lo, lane_vec(lane, exp_lo));
        chk("rsp_hi", rsp_hi, lane_vec(lane, exp_hi));
        if (stall > 0) begin
            drive_req(~id, 1'b1, c_OP_ADD, '0, '0);
            ok = 1'b1;
            for (int i = 0; i < stall; i++) begin
                @(posedge clock);
                @(negedge clock);
                if (rsp_valid !== 1'b1 || rsp_id !== id || alu_a !== va ||
                    rsp_lo !== lane_vec(lane, exp_lo) || rsp_hi !== lane_vec(lane, exp_hi))
                    ok = 1'b0;
                chk("bp_ready_low", {req1_ready, req0_ready}, 2'b00);
            end
            chk("bp_stable", ok, 1'b1);
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;
        if (id) exp_cnt1++; else exp_cnt0++;
        chk("rsp_valid_clear", rsp_valid, 1'b0);
        chk("busy_after_exit", busy, 1'b0);
        chk("cnt0", cnt0, exp_cnt0);
        chk("cnt1", cnt1, exp_cnt1);
        if (stall > 0) begin
            // Other requester was valid through the exit edge but must not
            // have been accepted on it; it is offered ready only now.
            chk("exit_ready", {req1_ready, req0_ready}, id ? 2'b01 : 2'b10);
            drive_req(~id, 1'b0, c_OP_ADD, '0, '0);
            @(posedge clock);
            @(negedge clock);
            chk("drop_no_accept", busy, 1'b0);
        end
    endtask

    initial begin
        int   n;
        int   cyc;
        logic ok;

        vecs[0] = '{id: 1'b0, op: c_OP_ADD,  lane: 0,  a: 32'd5,         b: 32'd7,         exp_lo: 32'd12,        exp_hi: 32'd0};
        vecs[1] = '{id: 1'b1, op: c_OP_MULL, lane: 15, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, exp_lo: 32'h0000_0001, exp_hi: 32'hFFFF_FFFE};
        vecs[2] = '{id: 1'b0, op: c_OP_MULL, lane: 3,  a: 32'h0001_0000, b: 32'h0001_0000, exp_lo: 32'h0000_0000, exp_hi: 32'h0000_0001};
        vecs[3] = '{id: 1'b1, op: c_OP_ADD,  lane: 7,  a: 32'hFFFF_FFFF, b: 32'h0000_0001, exp_lo: 32'h0000_0000, exp_hi: 32'h0000_0001};
        vecs[4] = '{id: 1'b0, op: c_OP_ADD,  lane: 15, a: 32'h1234_5678, b: 32'h1111_1111, exp_lo: 32'h2345_6789, exp_hi: 32'h0000_0000};
        vecs[5] = '{id: 1'b1, op: c_OP_MULL, lane: 0,  a: 32'd3,         b: 32'd7,         exp_lo: 32'd21,        exp_hi: 32'd0};
        vecs[6] = '{id: 1'b0, op: c_OP_MULL, lane: 9,  a: 32'h8000_0000, b: 32'd2,         exp_lo: 32'h0000_0000, exp_hi: 32'h0000_0001};
        vecs[7] = '{id: 1'b1, op: c_OP_ADD,  lane: 11, a: 32'hDEAD_BEEF, b: 32'h0101_0101, exp_lo: 32'hDFAE_BFF0, exp_hi: 32'h0000_0000};

        drive_req(1'b0, 1'b0, c_OP_ADD, '0, '0);
        drive_req(1'b1, 1'b0, c_OP_ADD, '0, '0);
        rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_id", rsp_id, 1'b0);
        chk("rst_rsp_lo", rsp_lo, '0);
        chk("rst_rsp_hi", rsp_hi, '0);
        chk("rst_alu_op", alu_op, 1'b0);
        chk("rst_alu_a", alu_a, '0);
        chk("rst_alu_b", alu_b, '0);
        chk("rst_cnt0", cnt0, 16'd0);
        chk("rst_cnt1", cnt1, 16'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", {req1_ready, req0_ready}, 2'b00);
        reset_n = 1'b1;

        // Single-request vectors
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].id, vecs[i].op, vecs[i].lane, vecs[i].a, vecs[i].b,
                   vecs[i].exp_lo, vecs[i].exp_hi, 0);
        end

        // Backpressure: 10 cycles of rsp_ready=0 with the other requester waiting
        run_op(1'b0, c_OP_ADD, 2, 32'd100, 32'd23, 32'd123, 32'd0, 10);

        // rsp_ready outside RESP is ignored
        @(negedge clock);
        rsp_ready = 1'b1;
        repeat (3) @(negedge clock);
        rsp_ready = 1'b0;
        chk("idle_rdy_cnt0", cnt0, exp_cnt0);
        chk("idle_rdy_cnt1", cnt1, exp_cnt1);
        chk("idle_rdy_busy", busy, 1'b0);

        // Contention after a fresh reset: grants alternate 0,1,0,1
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        exp_cnt0 = 16'd0;
        exp_cnt1 = 16'd0;
        drive_req(1'b0, 1'b1, c_OP_ADD, lane_vec(0, 32'd1), lane_vec(0, 32'd1));
        drive_req(1'b1, 1'b1, c_OP_ADD, lane_vec(0, 32'd2), lane_vec(0, 32'd2));
        rsp_ready = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 4 && cyc < 80) begin
            @(posedge clock);
            @(negedge clock);
            cyc++;
            if (rsp_valid) begin
                chk("cont_id", rsp_id, n % 2);
                chk("cont_lo", rsp_lo, lane_vec(0, (n % 2 == 1) ? 32'd4 : 32'd2));
                n++;
                if (n == 4) begin
                    drive_req(1'b0, 1'b0, c_OP_ADD, '0, '0);
                    drive_req(1'b1, 1'b0, c_OP_ADD, '0, '0);
                end
            end
        end
        chk("cont_count", n, 4);
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;
        exp_cnt0 = 16'd2;
        exp_cnt1 = 16'd2;
        chk("cont_cnt0", cnt0, exp_cnt0);
        chk("cont_cnt1", cnt1, exp_cnt1);
        chk("cont_busy", busy, 1'b0);

        // Reset one cycle after an accept of req0 (pointer then points at req1)
        @(negedge clock);
        drive_req(1'b0, 1'b1, c_OP_MULL, lane_vec(0, 32'd9), lane_vec(0, 32'd9));
        @(posedge clock);
        @(negedge clock);
        drive_req(1'b0, 1'b0, c_OP_ADD, '0, '0);
        chk("mid_busy", busy, 1'b1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_alu_op", alu_op, 1'b0);
        chk("mid_rst_alu_a", alu_a, '0);
        chk("mid_rst_alu_b", alu_b, '0);
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk("mid_rst_cnt0", cnt0, 16'd0);
        chk("mid_rst_cnt1", cnt1, 16'd0);
        exp_cnt0 = 16'd0;
        exp_cnt1 = 16'd0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        ok = 1'b1;
        repeat (4) begin
            @(posedge clock);
            @(negedge clock);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        chk("mid_no_response", ok, 1'b1);
        drive_req(1'b0, 1'b1, c_OP_ADD, lane_vec(0, 32'd5), lane_vec(0, 32'd7));
        drive_req(1'b1, 1'b1, c_OP_ADD, lane_vec(0, 32'd1), lane_vec(0, 32'd1));
        #1;
        chk("post_rst_grant", {req1_ready, req0_ready}, 2'b01);
        drive_req(1'b0, 1'b0, c_OP_ADD, '0, '0);
        drive_req(1'b1, 1'b0, c_OP_ADD, '0, '0);
        @(posedge clock);
        @(negedge clock);
        chk("withdraw_no_accept", busy, 1'b0);
        run_op(1'b0, c_OP_ADD, 0, 32'd5, 32'd7, 32'd12, 32'd0, 0);

        // Counter wrap: preload cnt0 to 0xFFFF, then one more req0 response
        @(negedge clock);
        force dut.r_cnt0 = 16'hFFFF;
        repeat (2) @(negedge clock);
        release dut.r_cnt0;
        exp_cnt0 = 16'hFFFF;
        @(negedge clock);
        chk("preload_cnt0", cnt0, exp_cnt0);
        run_op(1'b0, c_OP_ADD, 1, 32'd1, 32'd2, 32'd3, 32'd0, 0);
        chk("wrap_cnt0", cnt0, 16'h0000);
        chk("wrap_cnt1", cnt1, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
